// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with stall/flush and NOP bubble insertion.
// Define PIPE_STAGE_SKID_EN to add a skid entry that registers the upstream ready path.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | no entry held, output shows NOP_VALUE
// ST_ONE   | main register holds the output payload
// ST_TWO   | main and skid both full (skid build only)
module pipe_stage_hs #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_flag_i,
    input  logic             stall_flag_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1
    } state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] main_q;
`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q;
`endif
    logic             in_fire;
    logic             out_fire;

    // Encoding equals the entry count, so occupancy is the state register itself.
    assign occupancy_o = state;
    assign out_valid_o = (state != ST_EMPTY);
    // main_q is forced to NOP_VALUE whenever the stage drains, keeping out_data_o a pure register.
    assign out_data_o  = main_q;

`ifdef PIPE_STAGE_SKID_EN
    assign in_ready_o = ~rst & ~stall_flag_i & ~flush_flag_i & (state != ST_TWO);
`else
    assign in_ready_o = ~rst & ~stall_flag_i & ~flush_flag_i & (~out_valid_o | out_ready_i);
`endif

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i & ~stall_flag_i & ~flush_flag_i;

    always_ff @(posedge clk) begin
        if (rst || flush_flag_i) begin
            state  <= ST_EMPTY;
            main_q <= NOP_VALUE;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= NOP_VALUE;
`endif
        end else if (!stall_flag_i) begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state  <= ST_ONE;
                        main_q <= in_data_i;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data_i;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_fire) begin
                        state  <= ST_TWO;
                        skid_q <= in_data_i;
`endif
                    end else if (out_fire) begin
                        state  <= ST_EMPTY;
                        main_q <= NOP_VALUE;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_TWO: begin
                    if (out_fire) begin
                        state  <= ST_ONE;
                        main_q <= skid_q;
                        skid_q <= NOP_VALUE;
                    end
                end
`endif
                default: begin
                    state  <= ST_EMPTY;
                    main_q <= NOP_VALUE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: scoreboard of accepted payloads, checked on every output transfer.
module tb_pipe_stage_hs;

    localparam int          W   = 8;
    localparam logic [W-1:0] NOP = 8'h13;
`ifdef PIPE_STAGE_SKID_EN
    localparam int MAX_OCC = 2;
`else
    localparam int MAX_OCC = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         stall;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occ;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] sb[$];
    bit           last_in_fire;

    pipe_stage_hs #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_flag_i (flush),
        .stall_flag_i (stall),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .occupancy_o  (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks settled outputs against the model at negedge, then applies the edge's transfers to the model.
    task automatic cycle();
        logic exp_ready;
        logic [W-1:0] exp_data;
        @(negedge clk);
        if (MAX_OCC == 2)
            exp_ready = !rst && !stall && !flush && (sb.size() < 2);
        else
            exp_ready = !rst && !stall && !flush && (sb.size() == 0 || out_ready);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("occupancy", 64'(occ), 64'(sb.size()));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() == 0) chk("idle_nop", 64'(out_data), 64'(NOP));
        last_in_fire = in_valid && in_ready;
        if (out_valid && out_ready && !stall && !flush && !rst) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'(out_data), 64'(NOP));
            end else begin
                exp_data = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(exp_data));
            end
        end
        if (last_in_fire) sb.push_back(in_data);
        if (rst || flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] vals[3];
        logic [W-1:0] bp[3];
        int k;
        vals = '{8'h11, 8'h22, 8'h33};
        bp   = '{8'hA1, 8'hA2, 8'hA3};

        // reset with valid asserted
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        @(posedge clk); #1;
        cycle();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'(NOP));
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // streaming
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            cycle();
            chk("stream_data", 64'(out_data), 64'(vals[i]));
            chk("stream_occ", 64'(occ), 64'd1);
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_drain_occ", 64'(occ), 64'd0);

        // backpressure
        in_valid = 1'b1; in_data = bp[0]; out_ready = 1'b1;
        cycle();
        chk("bp_accept_a1", 64'(last_in_fire), 64'd1);
        k = 1;
        out_ready = 1'b0;
        repeat (3) begin
            in_data = bp[k];
            cycle();
            if (last_in_fire) k++;
        end
        chk("bp_occ", 64'(occ), 64'(MAX_OCC));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_held_upstream", 64'(k), 64'(MAX_OCC));
        out_ready = 1'b1;
        for (int c = 0; c < 12 && (k < 3 || sb.size() != 0); c++) begin
            in_valid = (k < 3);
            if (k < 3) in_data = bp[k];
            cycle();
            if (last_in_fire) k++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", 64'(k), 64'd3);
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // flush while full
        out_ready = 1'b0; in_valid = 1'b1;
        k = 0;
        repeat (3) begin
            in_data = 8'hB1 + 8'(k);
            cycle();
            if (last_in_fire) k++;
        end
        chk("flush_pre_occ", 64'(occ), 64'(MAX_OCC));
        in_data = 8'hFF; flush = 1'b1;
        cycle();
        chk("flush_no_accept", 64'(last_in_fire), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_occ", 64'(occ), 64'd0);
        chk("flush_nop", 64'(out_data), 64'(NOP));
        cycle();

        // stall holds output
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0; out_ready = 1'b1; stall = 1'b1;
        repeat (3) begin
            cycle();
            chk("stall_data", 64'(out_data), 64'h55);
            chk("stall_occ", 64'(occ), 64'd1);
            chk("stall_ready", 64'(in_ready), 64'd0);
        end
        stall = 1'b0;
        cycle();
        chk("stall_release_occ", 64'(occ), 64'd0);

        // flush beats stall
        in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0; flush = 1'b1; stall = 1'b1;
        cycle();
        flush = 1'b0; stall = 1'b0;
        chk("flush_stall_occ", 64'(occ), 64'd0);
        chk("flush_stall_valid", 64'(out_valid), 64'd0);

        // reset mid-transfer
        in_valid = 1'b1; in_data = 8'h77;
        cycle();
        in_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_occ", 64'(occ), 64'd0);
        chk("midrst_nop", 64'(out_data), 64'(NOP));
        out_ready = 1'b1;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised, handshaked pipeline stage register for the RV64 core pipeline, generalising the fixed-width stall/flush stage registers between ID, EX, MEM and WB. It carries one WIDTH-bit payload with valid/ready flow control, ctrl-driven stall and flush, and bubble insertion with a configurable NOP pattern. An optional 2-entry skid buffer registers the upstream ready path so variable-latency units (multi-cycle MUL/DIV, memory) can backpressure without a combinational ready chain through the pipeline.

## Interface
Parameters:
- WIDTH, 64, payload width in bits (1..256)
- NOP_VALUE, {WIDTH{1'b0}}, payload driven when stage is empty or flushed (e.g. 32'h00000013 for instruction fields)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- flush_flag_i  in  1  from ctrl; discard all held entries
- stall_flag_i  in  1  from ctrl; freeze stage (no accept, no release)
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept this cycle
- in_data_i  in  WIDTH  upstream payload
- out_valid_o  out  1  output payload valid
- out_ready_i  in  1  downstream accepts this cycle
- out_data_o  out  WIDTH  output payload; NOP_VALUE when out_valid_o=0
- occupancy_o  out  2  entries held (0, 1, 2)

## Operation
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i & ~stall_flag_i & ~flush_flag_i.
- Storage: main register (drives out_data_o) and, with skid enabled, one skid register.
- States: EMPTY (occ 0), ONE (main full), TWO (main + skid full; skid build only).
- EMPTY: in_fire -> ONE, main <= in_data_i.
- ONE: in_fire & out_fire -> ONE, main <= in_data_i; in_fire & ~out_fire -> TWO, skid <= in_data_i; ~in_fire & out_fire -> EMPTY; else hold.
- TWO: no accept; out_fire -> ONE, main <= skid; else hold.
- Ordering strictly FIFO; no payload dropped or duplicated except by flush.
- in_ready_o = ~stall_flag_i & ~flush_flag_i & (state != TWO) (skid build: registered-state only, no dependence on out_ready_i).
- out_valid_o = (state != EMPTY); out_data_o = main when valid, else NOP_VALUE.
- Flush: next state EMPTY, main and skid <= NOP_VALUE; in_ready_o=0 so no same-cycle accept; payload on output that cycle is not transferred.
- Stall: state and registers hold; in_ready_o=0; out_valid_o/out_data_o unchanged and stable.
- Priority: rst > flush_flag_i > stall_flag_i > handshake.
- Reset: state EMPTY, out_valid_o=0, out_data_o=NOP_VALUE, occupancy_o=0, skid=NOP_VALUE; in_ready_o=0 while rst high, 1 on first cycle after (absent stall/flush). Reset mid-transfer discards all entries.

## Timing
- Latency: in_fire at edge N -> out_valid_o with that payload after edge N (visible cycle N+1).
- Throughput: 1 payload/cycle sustained when out_ready_i=1 and no stall.
- Skid build: out_ready_i drop absorbed by skid; in_ready_o falls the cycle after entering TWO; no combinational path out_ready_i -> in_ready_o.
- Non-skid build: in_ready_o combinational from out_ready_i.
- All outputs except in_ready_o driven purely from registers.

## Configuration
- Macro PIPE_STAGE_SKID_EN.
- Defined: skid register and TWO state present; in_ready_o depends only on state, stall_flag_i, flush_flag_i; occupancy_o reaches 2.
- Undefined: no skid register, states EMPTY/ONE only; in_ready_o = ~stall_flag_i & ~flush_flag_i & (~out_valid_o | out_ready_i); occupancy_o never exceeds 1. All other behaviour identical.

## Test plan
- Reset: hold rst 2 cycles with in_valid_i=1 -> out_valid_o=0, out_data_o=NOP_VALUE, occupancy_o=0; in_ready_o=1 first cycle after release.
- Streaming: out_ready_i=1, send 0x11,0x22,0x33 on consecutive cycles -> out_data_o 0x11,0x22,0x33 on following consecutive cycles, occupancy_o=1 throughout.
- Backpressure (skid): send 0xA1,0xA2,0xA3, out_ready_i=0 after first accept -> occupancy_o=2, in_ready_o=0, 0xA3 held upstream; raise out_ready_i -> outputs 0xA1,0xA2,0xA3 in order.
- Flush while full: occupancy_o=2, pulse flush_flag_i with in_valid_i=1, data 0xFF -> next cycle occupancy_o=0, out_data_o=NOP_VALUE, 0xFF not accepted.
- Stall: with 0x55 on output, assert stall_flag_i 3 cycles, out_ready_i=1 -> out_data_o=0x55 stable, no out_fire, in_ready_o=0; release -> 0x55 consumed next edge.
- Simultaneous flush+stall with occupancy_o=1 -> flush wins: occupancy_o=0, out_valid_o=0 next cycle.
